// File: rtl/seg_scan_editor.sv
// N-digit multiplexed 7-segment scanner with a two-button hex editor and a parallel load port.
// Optional cursor blink is built when CURSOR_BLINK_EN is defined.
`timescale 1ns/1ps
module seg_scan_editor #(
    parameter int N_DIGITS  = 4,
    parameter int CLK_HZ    = 50000000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 4,
    parameter int DB_CYCLES = 250000,
    parameter int BLINK_HZ  = 2,
    localparam int CW       = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  inc,
    input  logic                  nxt,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [7:0]            seg_dat,
    output logic [N_DIGITS-1:0]   seg_sel,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [CW-1:0]         cursor
);
    localparam int SCAN_PERIOD = CLK_HZ / SCAN_HZ;
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int BW = $clog2(BLANK_CYC + 2);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_INIT = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    generate
        if (SCAN_PERIOD < BLANK_CYC + 2) begin : g_bad_scan
            $error("seg_scan_editor: CLK_HZ/SCAN_HZ must be >= BLANK_CYC+2");
        end
        if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_editor: N_DIGITS must be 2..8");
        end
        if (BLINK_HZ < 1) begin : g_bad_blink
            $error("seg_scan_editor: BLINK_HZ must be >= 1");
        end
    endgenerate

    // Button conditioning: bit 0 = inc, bit 1 = nxt
    logic [1:0] raw_btn;
    logic [1:0] btn_pulse;
    assign raw_btn = {nxt, inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg, sync2_reg, level_reg, pulse_reg;
            logic [DW-1:0] db_cnt_reg;
            always_ff @(posedge clk or posedge nRst) begin
                if (nRst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    level_reg  <= 1'b0;
                    pulse_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                    pulse_reg <= 1'b0;
                    if (sync2_reg != level_reg) begin
                        // This sample completes the run of DB_CYCLES differing samples
                        if (db_cnt_reg == DW'(DB_CYCLES - 1)) begin
                            level_reg  <= sync2_reg;
                            pulse_reg  <= sync2_reg;
                            db_cnt_reg <= '0;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + 1'b1;
                        end
                    end else begin
                        db_cnt_reg <= '0;
                    end
                end
            end
            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

    logic inc_p, nxt_p;
    assign inc_p = btn_pulse[0];
    assign nxt_p = btn_pulse[1];

    // Cursor: load forces 0 and swallows any same-cycle nxt
    logic [CW-1:0] cursor_reg;
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            cursor_reg <= '0;
        end else if (load) begin
            cursor_reg <= '0;
        end else if (nxt_p) begin
            cursor_reg <= (cursor_reg == CW'(N_DIGITS - 1)) ? '0 : cursor_reg + 1'b1;
        end
    end

    logic [4*N_DIGITS-1:0] digits_w;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [3:0] val_reg;
            always_ff @(posedge clk or posedge nRst) begin
                if (nRst) begin
                    val_reg <= 4'd0;
                end else if (load) begin
                    val_reg <= load_val[4*gi +: 4];
                end else if (inc_p && cursor_reg == CW'(gi)) begin
                    val_reg <= val_reg + 4'd1;
                end
            end
            assign digits_w[4*gi +: 4] = val_reg;
        end
    endgenerate

    logic blink_on;
`ifdef CURSOR_BLINK_EN
    localparam int BLINK_HALF = (CLK_HZ / BLINK_HZ) / 2;
    localparam int KW = $clog2(BLINK_HALF + 1);
    logic [KW-1:0] blink_cnt_reg;
    logic          blink_reg;
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else if (blink_cnt_reg == KW'(BLINK_HALF - 1)) begin
            blink_cnt_reg <= '0;
            blink_reg     <= ~blink_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end
    assign blink_on = blink_reg;
`else
    assign blink_on = 1'b0;
`endif

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 8'hC0;  4'h1: hex_glyph = 8'hF9;
            4'h2: hex_glyph = 8'hA4;  4'h3: hex_glyph = 8'hB0;
            4'h4: hex_glyph = 8'h99;  4'h5: hex_glyph = 8'h92;
            4'h6: hex_glyph = 8'h82;  4'h7: hex_glyph = 8'hF8;
            4'h8: hex_glyph = 8'h80;  4'h9: hex_glyph = 8'h90;
            4'hA: hex_glyph = 8'h88;  4'hB: hex_glyph = 8'h83;
            4'hC: hex_glyph = 8'hC6;  4'hD: hex_glyph = 8'hA1;
            4'hE: hex_glyph = 8'h86;  default: hex_glyph = 8'h8E;
        endcase
    endfunction

    logic [PW-1:0]       pre_cnt_reg;
    logic [CW-1:0]       scan_idx_reg;
    logic [BW-1:0]       blank_cnt_reg;
    logic                slot_shown_reg;
    logic [7:0]          seg_dat_reg;
    logic [N_DIGITS-1:0] seg_sel_reg;
    logic                scan_tick;
    logic [CW-1:0]       idx_next, drv_idx;
    logic [3:0]          drv_digit;
    logic [7:0]          drv_dat;
    logic [N_DIGITS-1:0] drv_sel;

    assign scan_tick = (pre_cnt_reg == PW'(SCAN_PERIOD - 1));
    assign idx_next  = (scan_idx_reg == CW'(N_DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
    assign drv_idx   = scan_tick ? idx_next : scan_idx_reg;
    assign drv_digit = digits_w[{drv_idx, 2'b00} +: 4];
    assign drv_sel   = ~(N_DIGITS'(1) << drv_idx);

    always_comb begin
        drv_dat = hex_glyph(drv_digit);
        if (drv_idx == cursor_reg) begin
            drv_dat[7] = 1'b0;
            if (blink_on) drv_dat = 8'hFF;
        end
    end

    // Slot contents are latched once per slot so mid-slot edits wait for the next slot
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            pre_cnt_reg    <= '0;
            scan_idx_reg   <= '0;
            blank_cnt_reg  <= '0;
            slot_shown_reg <= 1'b0;
            seg_dat_reg    <= 8'hFF;
            seg_sel_reg    <= '1;
        end else begin
            pre_cnt_reg <= scan_tick ? '0 : pre_cnt_reg + 1'b1;
            if (scan_tick) begin
                scan_idx_reg <= idx_next;
                if (BLANK_CYC == 0) begin
                    seg_sel_reg    <= drv_sel;
                    seg_dat_reg    <= drv_dat;
                    slot_shown_reg <= 1'b1;
                end else begin
                    blank_cnt_reg  <= BLANK_INIT;
                    seg_sel_reg    <= '1;
                    seg_dat_reg    <= 8'hFF;
                    slot_shown_reg <= 1'b0;
                end
            end else if (blank_cnt_reg != '0) begin
                blank_cnt_reg <= blank_cnt_reg - 1'b1;
            end else if (!slot_shown_reg) begin
                seg_sel_reg    <= drv_sel;
                seg_dat_reg    <= drv_dat;
                slot_shown_reg <= 1'b1;
            end
        end
    end

    assign seg_dat = seg_dat_reg;
    assign seg_sel = seg_sel_reg;
    assign digits  = digits_w;
    assign cursor  = cursor_reg;
endmodule

// File: tb/tb_seg_scan_editor.sv
// Randomised bench for seg_scan_editor against a press-level editing model and a time-based scan model.
`timescale 1ns/1ps
module tb_seg_scan_editor;
    localparam int N  = 4;
    localparam int DB = 3;
    localparam int SLOT = 10;   // CLK_HZ/SCAN_HZ
    localparam int BLK  = 2;

    logic        clk = 1'b0;
    logic        nRst, inc, nxt, load;
    logic [15:0] load_val;
    logic [7:0]  seg_dat;
    logic [3:0]  seg_sel;
    logic [15:0] digits;
    logic [1:0]  cursor;

    int checks = 0;
    int errors = 0;
    int t = 0;          // clock edges since reset release
    int m_dig [N];
    int m_cur;

    seg_scan_editor #(.N_DIGITS(N), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(BLK),
                      .DB_CYCLES(DB), .BLINK_HZ(2)) dut (
        .clk(clk), .nRst(nRst), .inc(inc), .nxt(nxt), .load(load), .load_val(load_val),
        .seg_dat(seg_dat), .seg_sel(seg_sel), .digits(digits), .cursor(cursor)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge nRst) begin
        if (nRst) t <= 0;
        else      t <= t + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [7:0] glyph(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [15:0] m_pack();
        logic [15:0] p = '0;
        for (int i = 0; i < N; i++) p[4*i +: 4] = 4'(m_dig[i]);
        return p;
    endfunction

    // Display expected from elapsed time: first slot starts right after reset,
    // every later slot begins with BLK dark cycles.
    function automatic logic [11:0] exp_scan(input int tt);
        int idx;
        logic [3:0] sel;
        logic [7:0] dat;
        if (tt == 0 || (tt >= SLOT && (tt % SLOT) < BLK)) return 12'hFFF;
        idx = (tt / SLOT) % N;
        sel = 4'hF;
        sel[idx] = 1'b0;
        dat = glyph(m_dig[idx]);
        if (idx == m_cur) dat[7] = 1'b0;
        return {sel, dat};
    endfunction

    task automatic scan_check(input int cycles);
        repeat (12) @(negedge clk);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("scan", {20'd0, seg_sel, seg_dat}, {20'd0, exp_scan(t)});
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_digits"}, {16'd0, digits}, {16'd0, m_pack()});
        check({tag, "_cursor"}, {30'd0, cursor}, {30'd0, 2'(m_cur)});
    endtask

    task automatic press(input logic do_inc, input logic do_nxt, input int hold);
        @(negedge clk);
        inc = do_inc;
        nxt = do_nxt;
        repeat (hold) @(negedge clk);
        inc = 1'b0;
        nxt = 1'b0;
        repeat (DB + 8) @(negedge clk);
        if (hold >= DB) begin
            if (do_inc) m_dig[m_cur] = (m_dig[m_cur] + 1) % 16;
            if (do_nxt) m_cur = (m_cur + 1) % N;
        end
        $display("press inc=%0b nxt=%0b hold=%0d -> digits=%h cursor=%0d", do_inc, do_nxt, hold, digits, cursor);
        check_state("press");
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < N; i++) m_dig[i] = int'(v[4*i +: 4]);
        m_cur = 0;
        $display("load %h -> digits=%h cursor=%0d", v, digits, cursor);
        check_state("load");
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 0;
        m_cur = 0;
    endtask

    initial begin
        logic [15:0] v;
        int kind, found;
        nRst = 1'b1; inc = 1'b0; nxt = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_dat", {24'd0, seg_dat}, 32'hFF);
        check("rst_sel", {28'd0, seg_sel}, 32'hF);
        check_state("rst");
        nRst = 1'b0;

        scan_check(40);
        press(1'b1, 1'b0, 2);          // bounce only
        press(1'b1, 1'b0, 10);
        scan_check(SLOT * N);

        do_load(16'hFEDC);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1'b1, 5);
            scan_check(SLOT * N);
        end

        press(1'b0, 1'b1, 4);
        press(1'b0, 1'b1, 4);          // cursor = 2
        press(1'b1, 1'b1, 5);          // inc at 2, cursor -> 3

        // load strobe lands on the same edge as the inc pulse
        v = 16'h3A5C;
        @(negedge clk);
        inc = 1'b1;
        repeat (5) @(negedge clk);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        inc = 1'b0;
        repeat (DB + 8) @(negedge clk);
        for (int i = 0; i < N; i++) m_dig[i] = int'(v[4*i +: 4]);
        m_cur = 0;
        $display("load+inc -> digits=%h cursor=%0d", digits, cursor);
        check_state("load_inc");

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: press(1'b1, 1'b0, int'($urandom_range(1, 6)));
                1: press(1'b0, 1'b1, int'($urandom_range(1, 6)));
                2: press(1'b1, 1'b1, int'($urandom_range(1, 6)));
                default: do_load(16'($urandom));
            endcase
        end
        scan_check(SLOT * N);

        // Reset during a blank gap with an inc press still being debounced
        found = 0;
        for (int k = 0; k < 3 * SLOT && found == 0; k++) begin
            @(negedge clk);
            if (seg_sel == 4'hF && t >= SLOT) found = 1;
        end
        check("blank_found", found, 1);
        inc = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 nRst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_dat", {24'd0, seg_dat}, 32'hFF);
        check("mid_rst_sel", {28'd0, seg_sel}, 32'hF);
        check_state("mid_rst");
        inc = 1'b0;
        @(negedge clk);
        nRst = 1'b0;
        repeat (20) @(negedge clk);
        $display("after reset release -> digits=%h cursor=%0d", digits, cursor);
        check_state("post_rst");
        scan_check(SLOT * N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
